// File: rtl/dualctx_addr_gen_if.sv
// dualctx_addr_gen_if: command, config and address-stream bundle for dualctx_addr_gen
// master: controller side (drives start/ctx/clear/yield/config/ready, observes stream)
// slave:  generator side (observes commands/config/ready, drives valid/addr/ctx/busy/done)
interface dualctx_addr_gen_if #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 16
);
  logic              i_start;
  logic              i_ctx;
  logic              i_clear;
  logic              i_yield;
  logic [ADDR_W-1:0] i_base;
  logic [CNT_W-1:0]  i_lim0;
  logic [CNT_W-1:0]  i_lim1;
  logic [CNT_W-1:0]  i_lim2;
  logic [CNT_W-1:0]  i_step0;
  logic [CNT_W-1:0]  i_step1;
  logic [CNT_W-1:0]  i_step2;
  logic              i_ready;
  logic              o_valid;
  logic [ADDR_W-1:0] o_addr;
  logic              o_ctx;
  logic              o_busy;
  logic              o_done;
  modport master (
    output i_start, i_ctx, i_clear, i_yield, i_base,
           i_lim0, i_lim1, i_lim2, i_step0, i_step1, i_step2, i_ready,
    input  o_valid, o_addr, o_ctx, o_busy, o_done
  );
  modport slave (
    input  i_start, i_ctx, i_clear, i_yield, i_base,
           i_lim0, i_lim1, i_lim2, i_step0, i_step1, i_step2, i_ready,
    output o_valid, o_addr, o_ctx, o_busy, o_done
  );
endinterface

// File: rtl/dualctx_addr_gen.sv
// dualctx_addr_gen: three-level nested-loop address generator with two resumable contexts
// i_clk/i_rstn: clock and asynchronous active-low reset
// bus (slave): start/ctx/clear/yield commands, base/limit/step config, valid/ready address stream
module dualctx_addr_gen #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  dualctx_addr_gen_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                         state_q, state_d;
  logic                           ctx_q, ctx_d;
  logic [1:0][2:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0][CNT_W-1:0]          lim, step, cur, nxt;
  logic [2:0]                     flag;
  logic                           hs;
  assign lim  = {bus.i_lim2, bus.i_lim1, bus.i_lim0};
  assign step = {bus.i_step2, bus.i_step1, bus.i_step0};
  assign cur  = cnt_q[ctx_q];
  // Increment wraps in CNT_W before the exclusive-limit compare
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      nxt[k]  = cur[k] + step[k];
      flag[k] = nxt[k] >= lim[k];
    end
  end
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    cnt_d   = cnt_q;
    hs      = (state_q == RUN) && bus.i_ready;
    // On the last element every flag is set, so the whole context wraps to 0
    if (hs) begin
      cnt_d[ctx_q][0] = flag[0] ? '0 : nxt[0];
      if (flag[0]) cnt_d[ctx_q][1] = flag[1] ? '0 : nxt[1];
      if (&flag[1:0]) cnt_d[ctx_q][2] = flag[2] ? '0 : nxt[2];
    end
    case (state_q)
      IDLE: if (bus.i_start) begin
        state_d = RUN;
        ctx_d   = bus.i_ctx;
      end
      RUN: if (hs && &flag) state_d = DONE;
        else if (hs && bus.i_yield) ctx_d = ~ctx_q;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.i_clear) begin
      state_d = IDLE;
      ctx_d   = 1'b0;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      ctx_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.o_valid = state_q == RUN;
  assign bus.o_addr  = bus.o_valid ? bus.i_base + ADDR_W'(cur[0]) + ADDR_W'(cur[1]) + ADDR_W'(cur[2]) : '0;
  assign bus.o_ctx   = ctx_q;
  assign bus.o_busy  = state_q != IDLE;
  assign bus.o_done  = state_q == DONE;
endmodule
